// File: rtl/mcs4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcs4 (package)
// Description : Shared types and constants for the MCS-4 family blocks:
//               4-bit character type, instruction-cycle phase enumeration,
//               the I/O-group OPR code and the I/O-group OPA sub-opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package mcs4;

    typedef logic [3:0] char_t;

    // One instruction cycle is eight steps: three address, two memory
    // (OPR, OPA), three execute.
    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    localparam char_t OPR_IO  = 4'hE;

    // I/O-group OPA sub-opcodes
    localparam char_t OPA_WRM = 4'h0;
    localparam char_t OPA_WMP = 4'h1;
    localparam char_t OPA_WRR = 4'h2;
    localparam char_t OPA_WPM = 4'h3;
    localparam char_t OPA_WR0 = 4'h4;
    localparam char_t OPA_WR1 = 4'h5;
    localparam char_t OPA_WR2 = 4'h6;
    localparam char_t OPA_WR3 = 4'h7;
    localparam char_t OPA_SBM = 4'h8;
    localparam char_t OPA_RDM = 4'h9;
    localparam char_t OPA_RDR = 4'hA;
    localparam char_t OPA_ADM = 4'hB;
    localparam char_t OPA_RD0 = 4'hC;
    localparam char_t OPA_RD1 = 4'hD;
    localparam char_t OPA_RD2 = 4'hE;
    localparam char_t OPA_RD3 = 4'hF;

endpackage
`default_nettype wire

// File: rtl/mcs4_timing.sv
`default_nettype none
// ============================================================================
// Module      : mcs4_timing
// Description : Instruction-cycle phase sequencer shared by the 4001/4002
//               models. Advances A1..X3 once per enabled step, parks at X3
//               until sync is seen, and restarts at A1 whenever sync is
//               sampled on a step.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               clken_2      - step enable
//               sync         - cycle start marker
//               phase        - current step phase
// Revision    : 1.0 - initial release
// ============================================================================
module mcs4_timing
    import mcs4::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clken_2,
    input  logic   sync,
    output phase_t phase
);

    phase_t r_phase;
    phase_t w_phase_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_X3;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        if (clken_2) begin
            if (sync) begin
                w_phase_nxt = PH_A1;
            end else begin
                case (r_phase)
                    PH_A1:   w_phase_nxt = PH_A2;
                    PH_A2:   w_phase_nxt = PH_A3;
                    PH_A3:   w_phase_nxt = PH_M1;
                    PH_M1:   w_phase_nxt = PH_M2;
                    PH_M2:   w_phase_nxt = PH_X1;
                    PH_X1:   w_phase_nxt = PH_X2;
                    PH_X2:   w_phase_nxt = PH_X3;
                    default: w_phase_nxt = PH_X3;
                endcase
            end
        end
    end

    assign phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/i4002_ram.sv
`default_nettype none
// ============================================================================
// Module      : i4002_ram
// Description : One 4002 RAM chip: 4 registers x (16 main + 4 status)
//               4-bit characters plus a 4-bit output port. Decodes SRC and
//               the I/O instruction group from the bus sequence.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               clken_1            - phase-1 enable (no effect)
//               clken_2            - step enable
//               sync               - cycle start marker
//               cm_ram             - bank command line
//               dbus_in            - resolved data bus
//               dbus_out, dbus_oe  - read data and its drive enable
//               io_out             - registered output port
// Revision    : 1.0 - initial release
// ============================================================================
module i4002_ram
    import mcs4::*;
#(
    parameter logic [1:0] CHIP_ID = 2'd0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clken_1,
    input  logic  clken_2,
    input  logic  sync,
    input  logic  cm_ram,
    input  char_t dbus_in,
    output char_t dbus_out,
    output logic  dbus_oe,
    output char_t io_out
);

    phase_t     w_phase;
    char_t      r_opr;
    char_t      r_opa;
    logic       r_io_cmd;
    logic       r_sel;
    logic [7:0] r_addr;
    logic       r_src_pend;   // SRC high nibble taken, low nibble due at X3
    char_t      r_io_out;
    char_t      r_main [4][16];
    char_t      r_stat [4][4];

    logic       w_io_op;
    logic [1:0] w_reg;
    logic [3:0] w_chr;
    logic       w_rd_en;
    char_t      w_rd_data;
    logic       w_unused;

    assign w_unused = clken_1;

    mcs4_timing u_timing (
        .clk     (clk),
        .rst     (rst),
        .clken_2 (clken_2),
        .sync    (sync),
        .phase   (w_phase)
    );

    assign w_io_op = r_io_cmd && (r_opr == OPR_IO) && r_sel;
    assign w_reg   = r_addr[5:4];
    assign w_chr   = r_addr[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opr      <= '0;
            r_opa      <= '0;
            r_io_cmd   <= 1'b0;
            r_sel      <= 1'b0;
            r_addr     <= '0;
            r_src_pend <= 1'b0;
            r_io_out   <= '0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 16; c++) begin
                    r_main[r][c] <= '0;
                end
                for (int s = 0; s < 4; s++) begin
                    r_stat[r][s] <= '0;
                end
            end
        end else if (clken_2) begin
            case (w_phase)
                PH_A1: begin
                    // A cycle restarted before X3 must not complete a stale SRC
                    r_src_pend <= 1'b0;
                end
                PH_M1: begin
                    r_opr <= dbus_in;
                end
                PH_M2: begin
                    r_opa    <= dbus_in;
                    r_io_cmd <= cm_ram;
                end
                PH_X2: begin
                    if (cm_ram) begin
                        r_addr[7:4] <= dbus_in;
                        r_src_pend  <= 1'b1;
                    end
                    // Writes use the address as it stood before this step
                    if (w_io_op) begin
                        case (r_opa)
                            OPA_WRM: r_main[w_reg][w_chr] <= dbus_in;
                            OPA_WMP: r_io_out <= dbus_in;
                            OPA_WR0, OPA_WR1, OPA_WR2, OPA_WR3:
                                r_stat[w_reg][r_opa[1:0]] <= dbus_in;
                            default: ;
                        endcase
                    end
                end
                PH_X3: begin
                    if (r_src_pend) begin
                        r_addr[3:0] <= dbus_in;
                        r_sel       <= (r_addr[7:6] == CHIP_ID);
                        r_src_pend  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_data = r_main[w_reg][w_chr];
        case (r_opa)
            OPA_SBM, OPA_RDM, OPA_ADM: w_rd_en = 1'b1;
            OPA_RD0, OPA_RD1, OPA_RD2, OPA_RD3: begin
                w_rd_en   = 1'b1;
                w_rd_data = r_stat[w_reg][r_opa[1:0]];
            end
            default: ;
        endcase
    end

    assign dbus_oe  = w_io_op && w_rd_en && (w_phase == PH_X2);
    assign dbus_out = dbus_oe ? w_rd_data : 4'h0;
    assign io_out   = r_io_out;

endmodule
`default_nettype wire

// File: tb/tb_i4002_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_i4002_ram
// Description : Self-checking bench for i4002_ram. Drives whole instruction
//               cycles step by step, with idle clocks between steps, and
//               compares against an instruction-level model of the chip.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i4002_ram;
    import mcs4::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  clken_1;
    logic  clken_2;
    logic  sync;
    logic  cm_ram;
    char_t dbus_in;
    char_t dbus_out;
    logic  dbus_oe;
    char_t io_out;

    int n_cmp = 0;
    int n_err = 0;

    // Instruction-level model
    char_t      m_main [4][16];
    char_t      m_stat [4][4];
    char_t      m_io;
    logic       m_sel;
    logic [7:0] m_addr;

    i4002_ram #(.CHIP_ID(2'd0)) dut (
        .clk      (clk),
        .rst      (rst),
        .clken_1  (clken_1),
        .clken_2  (clken_2),
        .sync     (sync),
        .cm_ram   (cm_ram),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out),
        .dbus_oe  (dbus_oe),
        .io_out   (io_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic char_t rnd();
        return char_t'($urandom);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) m_main[r][c] = 4'h0;
            for (int s = 0; s < 4; s++) m_stat[r][s] = 4'h0;
        end
        m_io   = 4'h0;
        m_sel  = 1'b0;
        m_addr = 8'h00;
    endtask

    // Idle clocks (clken_2 low) carry garbage on every other input
    task automatic step(input logic s, input logic cm, input char_t d, input int stall);
        for (int i = 0; i < stall; i++) begin
            clken_2 = 1'b0;
            sync    = 1'($urandom);
            cm_ram  = 1'($urandom);
            dbus_in = rnd();
            clken_1 = 1'($urandom);
            @(posedge clk);
            #1;
        end
        clken_2 = 1'b1;
        sync    = s;
        cm_ram  = cm;
        dbus_in = d;
        clken_1 = 1'($urandom);
        @(posedge clk);
        #1;
        clken_2 = 1'b0;
        sync    = 1'b0;
    endtask

    function automatic int rs();
        return ($urandom_range(0, 3) == 0) ? 1 : 0;
    endfunction

    // One full cycle starting at A1; the X3 step carries sync so the next
    // cycle starts at A1 again.
    task automatic run_cycle(input char_t opr, input char_t opa, input logic cm_m2,
                             input logic cm_x2, input char_t x2d, input char_t x3d,
                             input int stall_x1, output logic oe_x2, output char_t d_x2);
        logic  io;
        logic  e_oe;
        char_t e_d;
        logic [1:0] rg;
        rg = m_addr[5:4];
        step(1'b0, 1'b0, rnd(), rs());
        step(1'b0, 1'b0, rnd(), rs());
        step(1'b0, 1'b0, rnd(), rs());
        step(1'b0, 1'b0, opr,  rs());
        step(1'b0, cm_m2, opa, rs());
        chk("oe_before_x2", 8'(dbus_oe), 8'h00);
        step(1'b0, 1'b0, rnd(), stall_x1);
        io   = cm_m2 && (opr == OPR_IO) && m_sel;
        e_oe = io && (opa inside {4'h8, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF});
        e_d  = 4'h0;
        if (e_oe) e_d = (opa >= 4'hC) ? m_stat[rg][opa - 4'hC] : m_main[rg][m_addr[3:0]];
        oe_x2 = dbus_oe;
        d_x2  = dbus_out;
        chk("x2_oe", 8'(dbus_oe), 8'(e_oe));
        chk("x2_data", 8'(dbus_out), 8'(e_d));
        step(1'b0, cm_x2, x2d, rs());
        if (io) begin
            if (opa == 4'h0) m_main[rg][m_addr[3:0]] = x2d;
            else if (opa == 4'h1) m_io = x2d;
            else if (opa >= 4'h4 && opa <= 4'h7) m_stat[rg][opa - 4'h4] = x2d;
        end
        chk("x3_oe", 8'(dbus_oe), 8'h00);
        chk("x3_data", 8'(dbus_out), 8'h00);
        chk("io_out", 8'(io_out), 8'(m_io));
        step(1'b1, 1'b0, x3d, rs());
        if (cm_x2) begin
            m_addr = {x2d, x3d};
            m_sel  = (x2d[3:2] == 2'd0);
        end
    endtask

    task automatic src(input logic [7:0] a);
        logic  o;
        char_t d;
        run_cycle(4'h2, {rnd() | 4'h1}, 1'b0, 1'b1, a[7:4], a[3:0], 0, o, d);
    endtask

    task automatic io_op(input char_t opa, input char_t x2d, input int stall_x1,
                         output logic o, output char_t d);
        run_cycle(OPR_IO, opa, 1'b1, 1'b0, x2d, rnd(), stall_x1, o, d);
    endtask

    initial begin
        logic  o;
        char_t d;
        char_t opr;
        char_t opa;
        logic  cm2;
        int    k;
        clken_1 = 1'b0;
        clken_2 = 1'b0;
        sync    = 1'b0;
        cm_ram  = 1'b0;
        dbus_in = 4'h0;
        rst     = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oe", 8'(dbus_oe), 8'h00);
        chk("rst_data", 8'(dbus_out), 8'h00);
        chk("rst_io", 8'(io_out), 8'h00);
        rst = 1'b0;
        step(1'b1, 1'b0, rnd(), 0);

        // Write then read back main memory
        src(8'h25);
        io_op(OPA_WRM, 4'h7, 0, o, d);
        src(8'h25);
        io_op(OPA_RDM, rnd(), 0, o, d);
        chk("rdm_oe", 8'(o), 8'h01);
        chk("rdm_val", 8'(d), 8'h07);

        // Output port write and hold through a non-I/O cycle
        io_op(OPA_WMP, 4'hA, 0, o, d);
        chk("wmp_io", 8'(io_out), 8'h0A);
        run_cycle(4'h5, rnd(), 1'b0, 1'b0, rnd(), rnd(), 0, o, d);
        chk("wmp_hold", 8'(io_out), 8'h0A);

        // Other chip selected: nothing written, nothing driven
        src(8'h40);
        io_op(OPA_WRM, 4'h5, 0, o, d);
        io_op(OPA_RDM, rnd(), 0, o, d);
        chk("desel_oe", 8'(o), 8'h00);
        src(8'h00);
        io_op(OPA_RDM, rnd(), 0, o, d);
        chk("desel_nowrite", 8'(d), 8'h00);

        // Status characters
        src(8'h10);
        io_op(OPA_WR2, 4'h3, 0, o, d);
        io_op(OPA_RD2, rnd(), 0, o, d);
        chk("rd2", 8'(d), 8'h03);
        io_op(OPA_RD1, rnd(), 0, o, d);
        chk("rd1", 8'(d), 8'h00);

        // Sync mid-cycle aborts a WRM before its X2 step
        src(8'h25);
        step(1'b0, 1'b0, rnd(), 0);
        step(1'b0, 1'b0, rnd(), 0);
        step(1'b0, 1'b0, rnd(), 0);
        step(1'b0, 1'b0, OPR_IO, 0);
        step(1'b0, 1'b1, OPA_WRM, 0);
        step(1'b1, 1'b0, rnd(), 0);
        io_op(OPA_RDM, rnd(), 0, o, d);
        chk("abort_keep", 8'(d), 8'h07);

        // Long stall mid-cycle
        io_op(OPA_WRM, 4'hC, 5, o, d);
        io_op(OPA_RDM, rnd(), 5, o, d);
        chk("stall_oe", 8'(o), 8'h01);
        chk("stall_val", 8'(d), 8'h0C);

        // Reset in the middle of an instruction
        step(1'b0, 1'b0, rnd(), 0);
        step(1'b0, 1'b0, rnd(), 0);
        step(1'b0, 1'b0, rnd(), 0);
        step(1'b0, 1'b0, OPR_IO, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("mrst_oe", 8'(dbus_oe), 8'h00);
        chk("mrst_data", 8'(dbus_out), 8'h00);
        chk("mrst_io", 8'(io_out), 8'h00);
        step(1'b1, 1'b0, rnd(), 0);
        src(8'h25);
        io_op(OPA_RDM, rnd(), 0, o, d);
        chk("mrst_read", 8'(d), 8'h00);
        chk("mrst_read_oe", 8'(o), 8'h01);

        // Random instruction mix
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 2) begin
                src({($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                     2'($urandom), rnd()});
            end else if (k <= 8) begin
                io_op(rnd(), rnd(), $urandom_range(0, 2), o, d);
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    opr = rnd();
                    if (opr == OPR_IO) opr = 4'h3;
                    cm2 = 1'b1;
                end else begin
                    opr = OPR_IO;
                    cm2 = 1'b0;
                end
                opa = rnd();
                run_cycle(opr, opa, cm2, 1'b0, rnd(), rnd(), 0, o, d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i4002_ram.md
I4002_RAM -- requirements
Module: i4002_ram

Interface
REQ-001 CHIP_ID, 2'd0, chip number within the bank; it is matched against the SRC address bits [7:6].
REQ-002 clk  input  1  single system clock; every flop is clocked on the rising edge of clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 clken_1  input  1  phase-1 enable; it is accepted but has no effect on state.
REQ-005 clken_2  input  1  step enable; the phase advances and dbus_in is sampled only on clk edges where clken_2=1.
REQ-006 sync  input  1  when sampled high on a step, the next step is A1.
REQ-007 cm_ram  input  1  command line for this bank, pre-selected from mcs4::char_t cm_ram.
REQ-008 dbus_in  input  4  resolved data bus, as mcs4::char_t.
REQ-009 dbus_out  output  4  read data, as mcs4::char_t.
REQ-010 dbus_oe  output  1  high while the block drives dbus_out.
REQ-011 io_out  output  4  registered output port.

Function
REQ-012 Phase counter sequence: A1,A2,A3,M1,M2,X1,X2,X3; it holds at X3 until sync is sampled; sync on any step forces A1.
REQ-013 Storage: 4 registers x 16 main characters plus 4 registers x 4 status characters, all 4 bits wide.
REQ-014 M1 step: latch dbus_in as OPR.
REQ-015 M2 step: latch dbus_in as OPA and latch cm_ram as io_cmd.
REQ-016 SRC: cm_ram=1 at the X2 step latches dbus_in as addr[7:4]; the X3 step latches addr[3:0]; the chip becomes selected iff addr[7:6]==CHIP_ID.
REQ-017 I/O instruction: io_cmd=1, OPR=4'hE and selected=1; any other case is ignored with no state change.
REQ-018 Writes commit at the X2 step using dbus_in: E0 WRM writes main[addr[5:4]][addr[3:0]]; E1 WMP writes io_out; E4..E7 WR0..WR3 write status[addr[5:4]][OPA[1:0]].
REQ-019 Reads: E8 SBM, E9 RDM, EB ADM return main[reg][char]; EC..EF RD0..RD3 return status[reg][OPA[1:0]].
REQ-020 For a read, during phase X2 only: dbus_oe=1 and dbus_out=data; otherwise dbus_oe=0 and dbus_out=4'h0.
REQ-021 Reserved OPA values E2, E3, EA write nothing and do not drive the bus.
REQ-022 Selection and address persist across instruction cycles until the next SRC; an SRC with a non-matching chip number clears selected.
REQ-023 Steps are counted; raw clk edges with clken_2=0 change no state.
REQ-024 A sync arriving mid-cycle aborts the current cycle; a write whose X2 step has not occurred is dropped.

Reset
REQ-025 On rst=1 at a clk edge: phase=X3, OPR=OPA=0, io_cmd=0, selected=0, addr=0, io_out=0, all main and status characters cleared to 0, dbus_oe=0, dbus_out=0.
REQ-026 rst takes priority over clken_2 and sync.

Structure
REQ-027 Package mcs4: char_t, the phase_t enum, OPR_IO=4'hE, and the I/O OPA constants.
REQ-028 Sub-module mcs4_timing, the phase sequencer, is reused by i4001 and i4002.

Verification
REQ-029 SRC with addr 0x25 for CHIP_ID=0, then WRM with 4'h7 -> a later SRC 0x25 plus RDM drives dbus_out=7 and dbus_oe=1 in X2 only.
REQ-030 WMP with 4'hA -> io_out=A from the X2 step onward; io_out holds through a following non-I/O cycle.
REQ-031 SRC 0x40 for CHIP_ID=0 followed by WRM -> no write; a subsequent RDM is not driven and dbus_oe stays 0.
REQ-032 WR2 with 4'h3 at register 1 (SRC 0x10), then RD2 -> 3; RD1 -> 0.
REQ-033 rst asserted mid-instruction after a write -> all outputs 0; reading the written location returns 0.
REQ-034 clken_2 held low for 5 clocks mid-cycle -> the phase does not advance and the transaction completes correctly afterward.
